// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 RegFile: post-reset clear, then round-robin ALU/MEM writeback arbitration.
// Latency 1 cycle handshake->write; requesters stall via ready. Define REGARB_FIXED_PRIO_EN for fixed MEM priority.
module regfile_wb_arbiter #(
    parameter int NREGS          = 32,
    parameter int AW             = 5,
    parameter int DW             = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rw,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rw,
    input  logic [DW-1:0] mem_data,
    output logic          regwr,
    output logic [AW-1:0] rw,
    output logic [DW-1:0] busw,
    output logic          busy,
    output logic          last_grant
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [AW:0] LP_NREGS = (AW+1)'(NREGS);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_cnt;
    logic          w_alu_gnt;
    logic          w_mem_gnt;
    logic [AW-1:0] w_rw_sel;
    logic [DW-1:0] w_dat_sel;

    always_ff @(posedge clk) begin
        if (reset) r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_alu_gnt   = 1'b0;
        w_mem_gnt   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (r_cnt == LP_NREGS) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
`ifdef REGARB_FIXED_PRIO_EN
                w_mem_gnt = mem_valid;
                w_alu_gnt = alu_valid && !mem_valid;
`else
                // On contention the requester not served last time wins
                if (alu_valid && mem_valid) begin
                    w_alu_gnt = last_grant;
                    w_mem_gnt = !last_grant;
                end else begin
                    w_alu_gnt = alu_valid;
                    w_mem_gnt = mem_valid;
                end
`endif
            end
            default: w_state_nxt = ST_RUN;
        endcase
        // A handshake in a reset cycle would be dropped, so never advertise it
        if (reset) begin
            w_alu_gnt = 1'b0;
            w_mem_gnt = 1'b0;
        end
    end

    assign alu_ready = w_alu_gnt;
    assign mem_ready = w_mem_gnt;
    assign w_rw_sel  = w_mem_gnt ? mem_rw   : alu_rw;
    assign w_dat_sel = w_mem_gnt ? mem_data : alu_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            regwr      <= 1'b0;
            rw         <= '0;
            busw       <= '0;
            busy       <= CLEAR_ON_RESET;
            last_grant <= 1'b1;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt < LP_NREGS) begin
                        regwr <= 1'b1;
                        rw    <= r_cnt[AW-1:0];
                        busw  <= '0;
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        regwr <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (w_alu_gnt || w_mem_gnt) begin
                        // $0 is hardwired zero: accept the write but suppress the strobe
                        regwr      <= (w_rw_sel != '0);
                        rw         <= w_rw_sel;
                        busw       <= w_dat_sel;
                        last_grant <= w_mem_gnt;
                    end else begin
                        regwr <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, directed clear/contention/reset sequences, randomized traffic vs model.
module tb_regfile_wb_arbiter;

`ifdef REGARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rw = '0, mem_rw = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        regwr, busy, last_grant;
    logic [4:0]  rw;
    logic [31:0] busw;

    regfile_wb_arbiter #(.NREGS(32), .AW(5), .DW(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rw(alu_rw), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rw(mem_rw), .mem_data(mem_data),
        .regwr(regwr), .rw(rw), .busw(busw), .busy(busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: clear phase is a countdown of remaining steps (32 writes + 1 exit step)
    int          m_pend = 33;
    logic        m_regwr = 1'b0, m_last = 1'b1;
    logic [4:0]  m_rw = '0;
    logic [31:0] m_busw = '0;
    logic        s_ar, s_mr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Returns 0 = no grant, 1 = ALU, 2 = MEM
    function automatic int winner(input logic rst, input logic av, input logic mv);
        if (rst || m_pend > 0) return 0;
        if (av && mv) return FIXED ? 2 : (m_last ? 1 : 2);
        if (mv) return 2;
        if (av) return 1;
        return 0;
    endfunction

    task automatic cycle(input logic rst,
                         input logic av, input logic [4:0] arw, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrw, input logic [31:0] md);
        int w;
        @(negedge clk);
        reset = rst; alu_valid = av; alu_rw = arw; alu_data = ad;
        mem_valid = mv; mem_rw = mrw; mem_data = md;
        #1;
        w = winner(rst, av, mv);
        s_ar = alu_ready; s_mr = mem_ready;
        chk("alu_ready", alu_ready, (w == 1));
        chk("mem_ready", mem_ready, (w == 2));
        @(posedge clk);
        if (rst) begin
            m_pend = 33; m_regwr = 0; m_rw = 0; m_busw = 0; m_last = 1;
        end else if (m_pend > 1) begin
            m_regwr = 1; m_rw = 5'(33 - m_pend); m_busw = 0; m_pend--;
        end else if (m_pend == 1) begin
            m_regwr = 0; m_pend = 0;
        end else if (w != 0) begin
            m_rw   = (w == 2) ? mrw : arw;
            m_busw = (w == 2) ? md : ad;
            m_regwr = (m_rw != 0);
            m_last = (w == 2);
        end else begin
            m_regwr = 0;
        end
        #1;
        chk("regwr", regwr, m_regwr);
        chk("rw", rw, m_rw);
        chk("busw", busw, m_busw);
        chk("busy", busy, (m_pend > 0));
        chk("last_grant", last_grant, m_last);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_and_clear();
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(33);
    endtask

    typedef struct {
        logic av; logic [4:0] arw; logic [31:0] ad;
        logic mv; logic [4:0] mrw; logic [31:0] md;
        logic ear; logic emr; logic ewr; logic [4:0] erw; logic [31:0] ebw; logic elast;
    } vec_t;
    vec_t tbl[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_clr;
        logic        a_v, m_v;
        logic [4:0]  a_rw, m_rwr;
        logic [31:0] a_d, m_d;
        logic        rr;

        // Table assumes the state right after a clear: last_grant=1, rw=31, busw=0
        tbl[0] = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        1, 0, 1, 5,  32'hDEADBEEF, 0};
        tbl[1] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 5,  32'hDEADBEEF, 0};
        tbl[2] = '{1, 3,  32'h11111111, 1, 4,  32'h22222222, 0, 1, 1, 4,  32'h22222222, 1};
        tbl[3] = '{1, 3,  32'h11111111, 1, 4,  32'h22222222, !FIXED, FIXED, 1,
                   FIXED ? 5'd4 : 5'd3, FIXED ? 32'h22222222 : 32'h11111111, FIXED};
        tbl[4] = '{1, 3,  32'h11111111, 1, 4,  32'h22222222, 0, 1, 1, 4,  32'h22222222, 1};
        tbl[5] = '{0, 0,  32'h0,        1, 0,  32'hFFFFFFFF, 0, 1, 0, 0,  32'hFFFFFFFF, 1};
        tbl[6] = '{1, 0,  32'h12345678, 0, 0,  32'h0,        1, 0, 0, 0,  32'h12345678, 0};
        tbl[7] = '{1, 31, 32'hA5A5A5A5, 0, 0,  32'h0,        1, 0, 1, 31, 32'hA5A5A5A5, 0};
        tbl[8] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 31, 32'hA5A5A5A5, 0};
        tbl[9] = '{1, 9,  32'h9,        1, 10, 32'h10,       0, 1, 1, 10, 32'h10,       1};

        // Reset then clear: 32 writes of zero to r0..r31, then idle
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("reset_regwr", regwr, 0);
        chk("reset_busy", busy, 1);
        n_clr = 0;
        for (int k = 0; k < 32; k++) begin
            cycle(0, 1, 5'd9, 32'h9, 1, 5'd10, 32'h10);
            n_clr += int'(regwr);
            chk("clear_rw", rw, k);
            chk("clear_busw", busw, 0);
        end
        chk("clear_count", n_clr, 32);
        idle(1);
        chk("clear_done_busy", busy, 0);
        chk("clear_done_regwr", regwr, 0);

        // Contention straight after clear: ALU first under round-robin
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 5'd3, 32'h11111111, 1, 5'd4, 32'h22222222);
            rr = (i % 2 == 0);
            chk("contend_rw", rw, (FIXED || !rr) ? 4 : 3);
            chk("contend_alu_rdy", s_ar, !FIXED && rr);
        end

        reset_and_clear();
        for (int i = 0; i < 10; i++) begin
            cycle(0, tbl[i].av, tbl[i].arw, tbl[i].ad, tbl[i].mv, tbl[i].mrw, tbl[i].md);
            chk($sformatf("tbl%0d_alu_ready", i), s_ar, tbl[i].ear);
            chk($sformatf("tbl%0d_mem_ready", i), s_mr, tbl[i].emr);
            chk($sformatf("tbl%0d_regwr", i), regwr, tbl[i].ewr);
            chk($sformatf("tbl%0d_rw", i), rw, tbl[i].erw);
            chk($sformatf("tbl%0d_busw", i), busw, tbl[i].ebw);
            chk($sformatf("tbl%0d_last", i), last_grant, tbl[i].elast);
        end

        // Reset in the same cycle as an ALU request to r7: write dropped, clear restarts at r0
        cycle(1, 1, 5'd7, 32'h77777777, 0, 0, 0);
        chk("midrst_regwr", regwr, 0);
        chk("midrst_busy", busy, 1);
        cycle(0, 1, 5'd7, 32'h77777777, 0, 0, 0);
        chk("midrst_first_rw", rw, 0);
        for (int k = 1; k < 33; k++) begin
            cycle(0, 1, 5'd7, 32'h77777777, 0, 0, 0);
            if (regwr && rw == 5'd7) chk("midrst_r7_data", busw, 0);
        end

        // Random traffic; a requester not yet accepted holds its request
        a_v = 0; m_v = 0; a_rw = 0; m_rwr = 0; a_d = 0; m_d = 0;
        for (int i = 0; i < 600; i++) begin
            if (!a_v || s_ar) begin
                a_v = ($urandom_range(0, 3) != 0); a_rw = 5'($urandom); a_d = $urandom;
            end
            if (!m_v || s_mr) begin
                m_v = ($urandom_range(0, 2) != 0); m_rwr = 5'($urandom); m_d = $urandom;
            end
            cycle(($urandom_range(0, 127) == 0), a_v, a_rw, a_d, m_v, m_rwr, m_d);
            if (reset) begin
                a_v = 0; m_v = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
